// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode 7-segment scanner with hex decode, leading-zero
// blanking, inter-digit blanking gap and a per-frame input snapshot.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_mask,
  input  logic       lz_blank,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic          BLANK_SKIP = (BLANK_CYCLES == 0);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    slot_reg, slot_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    anode_reg, anode_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          tick_reg, tick_next;

  logic [15:0]   digit_snap_reg;
  logic [3:0]    dp_mask_snap_reg;
  logic          lz_snap_reg;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic        blank_done, show_done, load_snap;
  logic [15:0] digits_live, digits_eff;
  logic [3:0]  dp_eff;
  logic        lz_eff;
  logic [6:0]  glyph [4];

  assign blank_done = BLANK_SKIP || (count_reg == BLANK_LAST);
  assign show_done  = (count_reg == SHOW_LAST);

  // Slot-0 entry uses the live inputs on the same edge they are captured,
  // so the first digit of a frame already reflects the new snapshot.
  assign load_snap = enable &&
                     (((state_reg == ST_BLANK) && blank_done && (slot_reg == 2'd0)) ||
                      (BLANK_SKIP && (state_reg == ST_SHOW) && show_done && (slot_reg == 2'd3)));

  assign digits_live = {digit3, digit2, digit1, digit0};
  assign digits_eff  = load_snap ? digits_live : digit_snap_reg;
  assign dp_eff      = load_snap ? dp_mask : dp_mask_snap_reg;
  assign lz_eff      = load_snap ? lz_blank : lz_snap_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic blank_w;
      if (gi == 0) begin : g_lsd
        assign blank_w = 1'b0;
      end else begin : g_upper
        assign blank_w = lz_eff && (digits_eff[15:4*gi] == '0);
      end
      assign glyph[gi] = blank_w ? 7'h7F : hex_glyph(digits_eff[4*gi +: 4]);
    end
  endgenerate

  logic       show_load;
  logic [1:0] show_slot;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    count_next = count_reg + 1'b1;
    anode_next = anode_reg;
    seg_next   = seg_reg;
    dp_next    = dp_reg;
    tick_next  = 1'b0;
    show_load  = 1'b0;
    show_slot  = slot_reg;

    if (!enable) begin
      state_next = ST_BLANK;
      slot_next  = 2'd0;
      count_next = '0;
      anode_next = 4'hF;
      seg_next   = 7'h7F;
      dp_next    = 1'b1;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          if (blank_done) begin
            state_next = ST_SHOW;
            count_next = '0;
            show_load  = 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_done) begin
            count_next = '0;
            slot_next  = slot_reg + 2'd1;
            tick_next  = (slot_reg == 2'd3);
            if (BLANK_SKIP) begin
              show_load = 1'b1;
              show_slot = slot_reg + 2'd1;
            end else begin
              state_next = ST_BLANK;
              anode_next = 4'hF;
              seg_next   = 7'h7F;
              dp_next    = 1'b1;
            end
          end
        end
        default: state_next = ST_BLANK;
      endcase

      if (show_load) begin
        anode_next = ~(4'b0001 << show_slot);
        seg_next   = glyph[show_slot];
        dp_next    = ~dp_eff[show_slot];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_BLANK;
      slot_reg         <= 2'd0;
      count_reg        <= '0;
      anode_reg        <= 4'hF;
      seg_reg          <= 7'h7F;
      dp_reg           <= 1'b1;
      tick_reg         <= 1'b0;
      digit_snap_reg   <= '0;
      dp_mask_snap_reg <= '0;
      lz_snap_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      count_reg <= count_next;
      anode_reg <= anode_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      tick_reg  <= tick_next;
      if (load_snap) begin
        digit_snap_reg   <= digits_live;
        dp_mask_snap_reg <= dp_mask;
        lz_snap_reg      <= lz_blank;
      end
    end
  end

  assign anode      = anode_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2
// (a frame is 4 x (2 blank + 4 show) = 24 cycles).
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] digit3 = 4'h0, digit2 = 4'h0, digit1 = 4'h0, digit0 = 4'h0;
  logic [3:0] dp_mask = 4'h0;
  logic       lz_blank = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dp_mask(dp_mask), .lz_blank(lz_blank),
    .anode(anode), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Cycle c counts rising edges since reset release / re-enable.
  function automatic bit lit(input int c);
    return (c % 6) >= 2;
  endfunction

  function automatic int slot_of(input int c);
    return (c / 6) % 4;
  endfunction

  function automatic logic [3:0] exp_anode(input int c);
    if (!lit(c)) return 4'hF;
    return ~(4'b0001 << slot_of(c));
  endfunction

  task automatic restart(input logic [15:0] d, input logic [3:0] dpm, input logic lz);
    @(negedge clk);
    reset = 1'b0;
    {digit3, digit2, digit1, digit0} = d;
    dp_mask = dpm;
    lz_blank = lz;
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (anode !== 4'hF) begin failures++; $display("FAIL reset_anode got=%h exp=F", anode); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    $display("test_reset done");
  endtask

  task automatic test_scan_order();
    logic [6:0] g [4];
    logic [6:0] es;
    g = '{7'h19, 7'h30, 7'h24, 7'h79};
    restart(16'h1234, 4'h0, 1'b0);
    for (int c = 0; c <= 24; c++) begin
      es = lit(c) ? g[slot_of(c)] : 7'h7F;
      checks++; if (anode !== exp_anode(c)) begin failures++; $display("FAIL scan_anode c=%0d got=%h exp=%h", c, anode, exp_anode(c)); end
      checks++; if (seg !== es) begin failures++; $display("FAIL scan_seg c=%0d got=%h exp=%h", c, seg, es); end
      checks++; if (dp !== 1'b1) begin failures++; $display("FAIL scan_dp c=%0d got=%b exp=1", c, dp); end
      checks++; if (frame_tick !== (c == 24)) begin failures++; $display("FAIL scan_tick c=%0d got=%b exp=%b", c, frame_tick, (c == 24)); end
      @(negedge clk);
    end
    $display("test_scan_order done");
  endtask

  task automatic test_lz_blank();
    logic [15:0] dv [5];
    logic        lzv [5];
    logic [27:0] ev [5];
    logic [27:0] e;
    logic [6:0]  es;
    dv  = '{16'h0005, 16'h0005, 16'h0010, 16'h0500, 16'h0000};
    lzv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    // packed {slot3, slot2, slot1, slot0} glyphs
    ev  = '{{7'h7F, 7'h7F, 7'h7F, 7'h12},
            {7'h40, 7'h40, 7'h40, 7'h12},
            {7'h7F, 7'h7F, 7'h79, 7'h40},
            {7'h7F, 7'h12, 7'h40, 7'h40},
            {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    for (int i = 0; i < 5; i++) begin
      restart(dv[i], 4'h0, lzv[i]);
      e = ev[i];
      for (int c = 0; c < 24; c++) begin
        es = lit(c) ? e[slot_of(c)*7 +: 7] : 7'h7F;
        checks++; if (anode !== exp_anode(c)) begin failures++; $display("FAIL lz_anode case=%0d c=%0d got=%h exp=%h", i, c, anode, exp_anode(c)); end
        checks++; if (seg !== es) begin failures++; $display("FAIL lz_seg case=%0d c=%0d got=%h exp=%h", i, c, seg, es); end
        @(negedge clk);
      end
      $display("test_lz_blank case %0d digits=%h lz=%b done", i, dv[i], lzv[i]);
    end
  endtask

  task automatic test_tearing();
    logic [6:0] es;
    restart(16'h0A00, 4'h0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      if (!lit(c)) es = 7'h7F;
      else if (slot_of(c) == 2) es = (c < 24) ? 7'h08 : 7'h0E;
      else es = 7'h40;
      checks++; if (seg !== es) begin failures++; $display("FAIL tear_seg c=%0d got=%h exp=%h", c, seg, es); end
      checks++; if (frame_tick !== (c == 24)) begin failures++; $display("FAIL tear_tick c=%0d got=%b exp=%b", c, frame_tick, (c == 24)); end
      if (c == 10) digit2 = 4'hF;
      @(negedge clk);
    end
    $display("test_tearing done");
  endtask

  task automatic test_dp();
    logic edp;
    restart(16'h1234, 4'b0101, 1'b0);
    for (int c = 0; c < 24; c++) begin
      edp = (lit(c) && (slot_of(c) == 0 || slot_of(c) == 2)) ? 1'b0 : 1'b1;
      checks++; if (dp !== edp) begin failures++; $display("FAIL dp c=%0d anode=%h got=%b exp=%b", c, anode, dp, edp); end
      @(negedge clk);
    end
    $display("test_dp done");
  endtask

  task automatic test_enable();
    logic [6:0] g [4];
    logic [6:0] es;
    g = '{7'h78, 7'h30, 7'h24, 7'h79};
    restart(16'h1234, 4'h0, 1'b0);
    for (int c = 0; c < 15; c++) @(negedge clk);
    checks++; if (anode !== 4'hB) begin failures++; $display("FAIL en_pre_anode got=%h exp=b", anode); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (anode !== 4'hF) begin failures++; $display("FAIL en_off_anode got=%h exp=f", anode); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL en_off_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL en_off_dp got=%b exp=1", dp); end
    digit0 = 4'h7;
    for (int c = 0; c < 12; c++) begin
      checks++; if (anode !== 4'hF) begin failures++; $display("FAIL en_hold_anode c=%0d got=%h exp=f", c, anode); end
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL en_hold_tick c=%0d got=%b exp=0", c, frame_tick); end
      @(negedge clk);
    end
    enable = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      es = lit(c) ? g[slot_of(c)] : 7'h7F;
      checks++; if (anode !== exp_anode(c)) begin failures++; $display("FAIL en_re_anode c=%0d got=%h exp=%h", c, anode, exp_anode(c)); end
      checks++; if (seg !== es) begin failures++; $display("FAIL en_re_seg c=%0d got=%h exp=%h", c, seg, es); end
      checks++; if (frame_tick !== (c == 24)) begin failures++; $display("FAIL en_re_tick c=%0d got=%b exp=%b", c, frame_tick, (c == 24)); end
      @(negedge clk);
    end
    $display("test_enable done");
  endtask

  task automatic test_async_reset();
    logic [6:0] g [4];
    logic [6:0] es;
    g = '{7'h19, 7'h30, 7'h24, 7'h79};
    restart(16'h1234, 4'b1111, 1'b0);
    for (int c = 0; c < 9; c++) @(negedge clk);
    checks++; if (anode !== 4'hD) begin failures++; $display("FAIL ar_pre_anode got=%h exp=d", anode); end
    #2 reset = 1'b0;
    #1;
    checks++; if (anode !== 4'hF) begin failures++; $display("FAIL ar_anode got=%h exp=f", anode); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL ar_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL ar_dp got=%b exp=1", dp); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL ar_tick got=%b exp=0", frame_tick); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      es = lit(c) ? g[slot_of(c)] : 7'h7F;
      checks++; if (anode !== exp_anode(c)) begin failures++; $display("FAIL ar_re_anode c=%0d got=%h exp=%h", c, anode, exp_anode(c)); end
      checks++; if (seg !== es) begin failures++; $display("FAIL ar_re_seg c=%0d got=%h exp=%h", c, seg, es); end
      @(negedge clk);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_lz_blank();
    test_tearing();
    test_dp();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
